// File: rtl/clock_divider_param.sv
// Runtime-programmable integer clock divider with registered clock_out, tick and load_ack.
// Optional CLOCK_DIVIDER_DUTY_EN adds a duty_value port for a programmable high-phase length.
`timescale 1ns/1ps
module clock_divider_param #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
`ifdef CLOCK_DIVIDER_DUTY_EN
    input  logic [WIDTH-1:0] duty_value,
`endif
    output logic             clock_out,
    output logic             tick,
    output logic             load_ack
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] n_reg, n_d;
    logic [WIDTH-1:0] h_reg, h_d;
    logic             clock_d, tick_d, ack_d;

    logic [WIDTH-1:0] n_in, h_in, l_len;

    // Ratios 0 and 1 cannot produce a legal waveform; treat them as 2.
    assign n_in  = (div_value < TWO) ? TWO : div_value;
    assign l_len = n_reg - h_reg;

`ifdef CLOCK_DIVIDER_DUTY_EN
    always_comb begin
        if (duty_value == '0)
            h_in = ONE;
        else if (duty_value >= n_in)
            h_in = n_in - ONE;
        else
            h_in = duty_value;
    end
`else
    assign h_in = n_in >> 1;
`endif

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            n_reg     <= WIDTH'(DEFAULT_DIV);
            h_reg     <= WIDTH'(DEFAULT_DIV >> 1);
            clock_out <= 1'b0;
            tick      <= 1'b0;
            load_ack  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            n_reg     <= n_d;
            h_reg     <= h_d;
            clock_out <= clock_d;
            tick      <= tick_d;
            load_ack  <= ack_d;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they leave from flops.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        n_d     = n_reg;
        h_d     = h_reg;
        clock_d = 1'b0;
        tick_d  = 1'b0;
        ack_d   = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = HIGH;
                    n_d     = n_in;
                    h_d     = h_in;
                    clock_d = 1'b1;
                    tick_d  = 1'b1;
                    ack_d   = 1'b1;
                end
            end
            HIGH: begin
                if (cnt == h_reg - ONE) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt + ONE;
                    clock_d = 1'b1;
                end
            end
            LOW: begin
                if (cnt == l_len - ONE) begin
                    cnt_d = '0;
                    // Period boundary: the only place new settings or a stop take effect.
                    if (enable) begin
                        state_d = HIGH;
                        n_d     = n_in;
                        h_d     = h_in;
                        clock_d = 1'b1;
                        tick_d  = 1'b1;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_divider_param.sv
// Randomized scoreboard bench for clock_divider_param against a period-level reference model.
`timescale 1ns/1ps
module tb_clock_divider_param;

    localparam int W = 16;

    logic         clock_in = 1'b0;
    logic         reset_n  = 1'b0;
    logic         enable   = 1'b1;
    logic [W-1:0] div_value  = W'(4);
    logic [W-1:0] duty_value = '0;
    logic         clock_out, tick, load_ack;

    clock_divider_param #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .div_value (div_value),
`ifdef CLOCK_DIVIDER_DUTY_EN
        .duty_value(duty_value),
`endif
        .clock_out (clock_out),
        .tick      (tick),
        .load_ack  (load_ack)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic co;
        logic tk;
        logic ak;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position within the current period plus the latched ratio.
    bit m_run = 0;
    int m_pos = 0;
    int m_n   = 4;
    int m_h   = 2;

    task automatic model_start(input int div, input int duty);
        m_run = 1;
        m_pos = 0;
        m_n   = (div < 2) ? 2 : div;
`ifdef CLOCK_DIVIDER_DUTY_EN
        m_h   = (duty < 1) ? 1 : ((duty > m_n - 1) ? m_n - 1 : duty);
`else
        m_h   = m_n / 2;
`endif
    endtask

    task automatic apply(input bit en, input int div, input int duty, input int cycles);
        exp_t e;
        repeat (cycles) begin
            enable     = en;
            div_value  = W'(div);
            duty_value = W'(duty);
            @(posedge clock_in);
            e = '0;
            if (!reset_n) begin
                m_run = 0;
                m_pos = 0;
            end else if (!m_run) begin
                if (en) begin
                    model_start(div, duty);
                    e.tk = 1'b1;
                    e.ak = 1'b1;
                end
            end else begin
                m_pos++;
                if (m_pos == m_n) begin
                    if (en) begin
                        model_start(div, duty);
                        e.tk = 1'b1;
                        e.ak = 1'b1;
                    end else begin
                        m_run = 0;
                        m_pos = 0;
                    end
                end
            end
            e.co = m_run && (m_pos < m_h);
            sb.push_back(e);
            #1;
        end
    endtask

    // Monitor: compares on every falling clock edge; an asynchronous reset that
    // lands while clock_in is high is checked immediately and voids the pending entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock_in or negedge reset_n);
            if (clock_in) begin
                #1;
                sb.delete();
                checks++;
                if ({clock_out, tick, load_ack} !== 3'b000) begin
                    errors++;
                    $display("FAIL async_reset got co/tk/ak=%b%b%b want 000 at %0t",
                             clock_out, tick, load_ack, $time);
                end
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({clock_out, tick, load_ack} !== {e.co, e.tk, e.ak}) begin
                    errors++;
                    $display("FAIL cycle got co/tk/ak=%b%b%b want %b%b%b at %0t",
                             clock_out, tick, load_ack, e.co, e.tk, e.ak, $time);
                end
            end
        end
    end

    initial begin
        // Held in reset with enable high: all outputs stay low.
        apply(1, 4, 2, 4);
        reset_n = 1'b1;
        apply(1, 4, 2, 16);
        // Odd ratio, then duty extremes (only meaningful with the duty port).
        apply(1, 5, 4, 15);
        apply(1, 5, 0, 10);
        // Clamp of 0 and 1.
        apply(1, 0, 0, 8);
        apply(1, 1, 0, 8);
        // Run at 6; change to 3 during the first HIGH cycle of a fresh period.
        apply(0, 6, 3, 8);
        apply(1, 6, 3, 1);
        apply(1, 3, 1, 14);
        // Stop at N=8 on the first HIGH cycle.
        apply(0, 8, 4, 6);
        apply(1, 8, 4, 1);
        apply(0, 8, 4, 14);
        // Async reset while HIGH at N=10, then clean restart.
        apply(1, 10, 5, 3);
        #1 reset_n = 1'b0;
        apply(1, 10, 5, 2);
        reset_n = 1'b1;
        apply(1, 10, 5, 25);
        // Random enable/ratio/duty traffic.
        for (int i = 0; i < 600; i++)
            apply(($urandom % 8) != 0, int'($urandom % 12), int'($urandom % 14), 1);
        apply(0, 4, 2, 16);
        @(negedge clock_in);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_param.md
# clock_divider_param

- Parametrised, runtime-programmable integer clock divider.
- Generates a registered divided clock `clock_out` from `clock_in`, plus a one-cycle `tick` strobe at each divided-clock rising edge.
- Divisor changes and enable/disable take effect only at period boundaries, so `clock_out` never produces a runt pulse.
- Used as the timebase generator for counters, debouncers and display scanning that need divide ratios chosen at run time.

## Interface
- `WIDTH`, default 16: width of the divisor (and duty) inputs and of the internal counter.
- `DEFAULT_DIV`, default 4: divisor in effect out of reset; must be ≥2.
- `clock_in`  input  1  system clock; all logic on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  run request; sampled every cycle.
- `div_value`  input  WIDTH  requested divide ratio N.
- `duty_value`  input  WIDTH  requested high-phase length; present only with `CLOCK_DIVIDER_DUTY_EN`.
- `clock_out`  output  1  registered divided clock.
- `tick`  output  1  one-cycle pulse, coincident with each cycle in which `clock_out` rises.
- `load_ack`  output  1  one-cycle pulse when the active divisor register (re)loads.

## Operation
- Reset (asynchronous, `reset_n`=0):
  - state IDLE; `clock_out`=0, `tick`=0, `load_ack`=0; counter=0.
  - Active divisor = `DEFAULT_DIV`; high length = `DEFAULT_DIV`>>1.
- Divisor clamp: effective N = max(`div_value`, 2); values 0 and 1 behave as 2.
- High length H:
  - Without the macro: H = N>>1, giving N=4 → 2/2 and N=5 → 2 high/3 low.
  - Low length L = N−H.
- States:
  - IDLE: `clock_out`=0. When `enable`=1, load N/H from inputs, go to HIGH, pulse `tick` and `load_ack`.
  - HIGH: `clock_out`=1; counter counts 0..H−1; at H−1 go to LOW, counter=0.
  - LOW: `clock_out`=0; counter counts 0..L−1. At L−1 (the period end):
    - if `enable`=1: reload N/H from current inputs, pulse `load_ack`, go to HIGH, pulse `tick`;
    - else: go to IDLE.
- Mid-period changes:
  - Changes to `div_value`/`duty_value` are ignored until the next period end.
  - Deasserting `enable` mid-period completes the current period, then stops low.
- Re-asserting `enable` before the period end: no effect on the period in progress.
- Counter arithmetic is unsigned WIDTH bits. N up to 2^WIDTH−1 is supported without wrap, because the counter never exceeds N−1.
- All outputs come directly from flops; no combinational path from inputs to outputs.

## Timing
- Enable latency: `enable` high at edge k while IDLE → `clock_out`=1 and `tick`=1 after edge k (visible in cycle k+1).
- Steady state:
  - `clock_out` period is exactly N `clock_in` cycles: H high, L low.
  - `tick` repeats every N cycles.
- Reload latency: a new `div_value` first governs the period that begins after the current period end. `load_ack` marks that boundary, coincident with `tick`.
- Stop latency: after `enable` drops, `clock_out` stays in its current period for at most N cycles, then stays 0. No `tick` occurs after the stop.
- Reset mid-period: `clock_out` drops to 0 immediately (asynchronously); operation restarts from IDLE after `reset_n` rises.

## Configuration
- `CLOCK_DIVIDER_DUTY_EN` defined:
  - Adds the `duty_value` port.
  - H = `duty_value` clamped to 1..N−1, latched together with N at load time.
- Not defined:
  - No `duty_value` port.
  - H = N>>1 (duty ≈50%, low phase longer by one cycle for odd N).

## Test plan
- Reset: hold `reset_n`=0 with `enable`=1 → `clock_out`=0, `tick`=0, `load_ack`=0. Release with `div_value`=4 → from the next cycle, pattern 1,1,0,0 repeating; `tick` every 4 cycles.
- Odd ratio: `div_value`=5, no macro → 2 high, 3 low. With macro and `duty_value`=4 → 4 high, 1 low; with `duty_value`=0 → 1 high, 4 low.
- Clamp: `div_value`=0, then 1 → both produce period 2 (1 high, 1 low).
- Reconfigure: running at N=6, change `div_value` to 3 in the first HIGH cycle → the current period still runs 6 cycles. `load_ack`+`tick` then fire together, and the following periods run 3 cycles (1 high/2 low).
- Stop: drop `enable` on the first cycle of HIGH with N=8 → the remaining 7 cycles of the period complete, then `clock_out` stays 0 with no further `tick`.
- Async reset mid-HIGH at N=10 → `clock_out` falls before the next `clock_in` edge. After release with `enable`=1, the divider restarts cleanly with a fresh full period.
